// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle MIPS-subset controller: opcodes, functs,
// ALU operation codes, FSM state codes and PC source selects.
package cpu_pkg;

    // Opcodes
    localparam logic [5:0] OpRType = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpSlti  = 6'h0A;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpXori  = 6'h0E;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
    localparam logic [5:0] OpHlt   = 6'h3F;

    // R-type funct codes
    localparam logic [5:0] FnSll  = 6'h00;
    localparam logic [5:0] FnSrl  = 6'h02;
    localparam logic [5:0] FnJr   = 6'h08;
    localparam logic [5:0] FnAdd  = 6'h20;
    localparam logic [5:0] FnAddu = 6'h21;
    localparam logic [5:0] FnSub  = 6'h22;
    localparam logic [5:0] FnSubu = 6'h23;
    localparam logic [5:0] FnAnd  = 6'h24;
    localparam logic [5:0] FnOr   = 6'h25;
    localparam logic [5:0] FnXor  = 6'h26;
    localparam logic [5:0] FnNor  = 6'h27;
    localparam logic [5:0] FnSlt  = 6'h2A;
    localparam logic [5:0] FnSgt  = 6'h2B;

    // ALU operation codes understood by the core ALU
    localparam logic [3:0] AluAdd = 4'd0;
    localparam logic [3:0] AluSub = 4'd1;
    localparam logic [3:0] AluAnd = 4'd2;
    localparam logic [3:0] AluOr  = 4'd3;
    localparam logic [3:0] AluXor = 4'd4;
    localparam logic [3:0] AluNor = 4'd5;
    localparam logic [3:0] AluSlt = 4'd6;
    localparam logic [3:0] AluSgt = 4'd7;
    localparam logic [3:0] AluSll = 4'd8;
    localparam logic [3:0] AluSrl = 4'd9;

    // FSM state codes
    typedef logic [2:0] state_t;
    localparam state_t StIdle   = 3'd0;
    localparam state_t StFetch  = 3'd1;
    localparam state_t StDecode = 3'd2;
    localparam state_t StExec   = 3'd3;
    localparam state_t StBranch = 3'd4;
    localparam state_t StMem    = 3'd5;
    localparam state_t StWb     = 3'd6;
    localparam state_t StHalt   = 3'd7;

    // PC source select
    localparam logic [1:0] PcSrcSeq    = 2'd0;
    localparam logic [1:0] PcSrcBranch = 2'd1;
    localparam logic [1:0] PcSrcJump   = 2'd2;
    localparam logic [1:0] PcSrcReg    = 2'd3;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Bundle between the controller (master) and the datapath/memories (slave).
interface multicycle_control_unit_if #(
    parameter int unsigned OPCODE_W = 6,
    parameter int unsigned FUNCT_W  = 6,
    parameter int unsigned ALUOP_W  = 4,
    parameter int unsigned CNT_W    = 32
);
    logic [OPCODE_W-1:0] opcode;
    logic [FUNCT_W-1:0]  funct;
    logic                alu_zero;
    logic                imem_ready;
    logic                dmem_ready;
    logic                imem_req;
    logic                PCWrite;
    logic [1:0]          PCSrc;
    logic                IRWrite;
    logic                RegDst;
    logic                MemReadEn;
    logic                MemtoReg;
    logic                MemWriteEn;
    logic                RegWriteEn;
    logic                ALUSrc;
    logic [ALUOP_W-1:0]  ALUOp;
    logic                hlt;
    logic                mem_err;
    logic [CNT_W-1:0]    cycle_cnt;
    logic [CNT_W-1:0]    retired_cnt;

    modport master (
        input  opcode, funct, alu_zero, imem_ready, dmem_ready,
        output imem_req, PCWrite, PCSrc, IRWrite, RegDst, MemReadEn, MemtoReg,
               MemWriteEn, RegWriteEn, ALUSrc, ALUOp, hlt, mem_err, cycle_cnt,
               retired_cnt
    );

    modport slave (
        output opcode, funct, alu_zero, imem_ready, dmem_ready,
        input  imem_req, PCWrite, PCSrc, IRWrite, RegDst, MemReadEn, MemtoReg,
               MemWriteEn, RegWriteEn, ALUSrc, ALUOp, hlt, mem_err, cycle_cnt,
               retired_cnt
    );
endinterface

// File: rtl/mcu_decode.sv
// Combinational decode of the latched opcode/funct into datapath controls.
module mcu_decode #(
    parameter int unsigned OPCODE_W = 6,
    parameter int unsigned FUNCT_W  = 6
) (
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic [FUNCT_W-1:0]  funct_i,
    output logic [3:0]          alu_op_o,
    output logic                alu_src_o,
    output logic                reg_dst_o,
    output logic                is_mem_o,
    output logic                is_branch_o,
    output logic                legal_o
);
    import cpu_pkg::*;

    logic [5:0] op;
    logic [5:0] fn;
    assign op = 6'(opcode_i);
    assign fn = 6'(funct_i);

    // Map opcode/funct onto ALU controls and instruction class flags
    always_comb begin
        alu_op_o    = AluAdd;
        alu_src_o   = 1'b0;
        reg_dst_o   = 1'b0;
        is_mem_o    = 1'b0;
        is_branch_o = 1'b0;
        legal_o     = 1'b1;
        case (op)
            OpRType: begin
                reg_dst_o = 1'b1;
                case (fn)
                    FnAdd, FnAddu: alu_op_o = AluAdd;
                    FnSub, FnSubu: alu_op_o = AluSub;
                    FnAnd:         alu_op_o = AluAnd;
                    FnOr:          alu_op_o = AluOr;
                    FnXor:         alu_op_o = AluXor;
                    FnNor:         alu_op_o = AluNor;
                    FnSlt:         alu_op_o = AluSlt;
                    FnSgt:         alu_op_o = AluSgt;
                    FnSll: begin
                        alu_op_o  = AluSll;
                        alu_src_o = 1'b1;
                    end
                    FnSrl: begin
                        alu_op_o  = AluSrl;
                        alu_src_o = 1'b1;
                    end
                    FnJr:          ;
                    default:       legal_o = 1'b0;
                endcase
            end
            OpJ, OpHlt: ;
            OpJal: begin
                reg_dst_o = 1'b1;
                alu_src_o = 1'b1;
            end
            OpBeq, OpBne: begin
                is_branch_o = 1'b1;
                alu_op_o    = AluSub;
            end
            OpAddi: alu_src_o = 1'b1;
            OpSlti: begin
                alu_src_o = 1'b1;
                alu_op_o  = AluSlt;
            end
            OpAndi: begin
                alu_src_o = 1'b1;
                alu_op_o  = AluAnd;
            end
            OpOri: begin
                alu_src_o = 1'b1;
                alu_op_o  = AluOr;
            end
            OpXori: begin
                alu_src_o = 1'b1;
                alu_op_o  = AluXor;
            end
            OpLw, OpSw: begin
                alu_src_o = 1'b1;
                is_mem_o  = 1'b1;
            end
            default: legal_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle controller: sequences FETCH/DECODE/EXEC/BRANCH/MEM/WB, times out
// stalled memories, and counts active cycles and retired instructions.
module multicycle_control_unit #(
    parameter int unsigned OPCODE_W     = 6,
    parameter int unsigned FUNCT_W      = 6,
    parameter int unsigned ALUOP_W      = 4,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input logic                       clk,
    input logic                       rst,
    multicycle_control_unit_if.master bus
);
    import cpu_pkg::*;

    localparam int unsigned WaitW = (MEM_WAIT_MAX > 2) ? $clog2(MEM_WAIT_MAX) : 1;
    // Value of the wait counter during the last tolerated low-ready cycle
    localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_WAIT_MAX - 1);

    state_t              state_q, state_d;
    logic [OPCODE_W-1:0] opcode_q;
    logic [FUNCT_W-1:0]  funct_q;
    logic [WaitW-1:0]    wait_q, wait_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cycle_q, retired_q;
    logic                retire, latch;

    logic [3:0] dec_alu_op;
    logic       dec_alu_src, dec_reg_dst, dec_is_mem, dec_is_branch, dec_legal;

    logic       imem_req, pc_write, ir_write, reg_dst, mem_read_en, mem_to_reg;
    logic       mem_write_en, reg_write_en, alu_src, hlt;
    logic [1:0] pc_src;
    logic [3:0] alu_op;

    logic is_lw, is_beq, is_j, is_jr, is_hlt;
    assign is_lw  = (opcode_q == OPCODE_W'(OpLw));
    assign is_beq = (opcode_q == OPCODE_W'(OpBeq));
    assign is_j   = (opcode_q == OPCODE_W'(OpJ));
    assign is_hlt = (opcode_q == OPCODE_W'(OpHlt));
    assign is_jr  = (opcode_q == OPCODE_W'(OpRType)) && (funct_q == FUNCT_W'(FnJr));

    mcu_decode #(
        .OPCODE_W(OPCODE_W),
        .FUNCT_W (FUNCT_W)
    ) u_decode (
        .opcode_i   (opcode_q),
        .funct_i    (funct_q),
        .alu_op_o   (dec_alu_op),
        .alu_src_o  (dec_alu_src),
        .reg_dst_o  (dec_reg_dst),
        .is_mem_o   (dec_is_mem),
        .is_branch_o(dec_is_branch),
        .legal_o    (dec_legal)
    );

    // Next state, wait/timeout tracking and per-state control outputs
    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        err_d        = err_q;
        retire       = 1'b0;
        latch        = 1'b0;
        imem_req     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = PcSrcSeq;
        ir_write     = 1'b0;
        reg_dst      = 1'b0;
        mem_read_en  = 1'b0;
        mem_to_reg   = 1'b0;
        mem_write_en = 1'b0;
        reg_write_en = 1'b0;
        alu_src      = 1'b0;
        alu_op       = AluAdd;
        hlt          = 1'b0;
        case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                imem_req = 1'b1;
                if (bus.imem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    latch    = 1'b1;
                    state_d  = StDecode;
                end else if (wait_q == WaitLast) begin
                    err_d   = 1'b1;
                    state_d = StHalt;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StDecode: begin
                if (is_hlt) begin
                    state_d = StHalt;
                end else if (is_j || is_jr) begin
                    pc_write = 1'b1;
                    pc_src   = is_j ? PcSrcJump : PcSrcReg;
                    retire   = 1'b1;
                    state_d  = StFetch;
                end else if (dec_is_branch) begin
                    state_d = StBranch;
                end else if (dec_legal) begin
                    state_d = StExec;
                end else begin
                    state_d = StFetch;
                end
            end
            StExec: begin
                alu_src = dec_alu_src;
                alu_op  = dec_alu_op;
                reg_dst = dec_reg_dst;
                state_d = dec_is_mem ? StMem : StWb;
            end
            StBranch: begin
                alu_op = AluSub;
                if (is_beq == bus.alu_zero) begin
                    pc_write = 1'b1;
                    pc_src   = PcSrcBranch;
                end
                retire  = 1'b1;
                state_d = StFetch;
            end
            StMem: begin
                alu_src      = 1'b1;
                mem_read_en  = is_lw;
                mem_write_en = !is_lw;
                if (bus.dmem_ready) begin
                    retire  = !is_lw;
                    state_d = is_lw ? StWb : StFetch;
                end else if (wait_q == WaitLast) begin
                    err_d   = 1'b1;
                    state_d = StHalt;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StWb: begin
                reg_write_en = 1'b1;
                mem_to_reg   = is_lw;
                reg_dst      = dec_reg_dst;
                retire       = 1'b1;
                state_d      = StFetch;
            end
            StHalt: hlt = 1'b1;
            default: state_d = StIdle;
        endcase
        if (state_d != state_q) begin
            wait_d = '0;
        end
    end

    // State, latched instruction fields, error flag and counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            opcode_q  <= '0;
            funct_q   <= '0;
            wait_q    <= '0;
            err_q     <= 1'b0;
            cycle_q   <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            if (latch) begin
                opcode_q <= bus.opcode;
                funct_q  <= bus.funct;
            end
            if (state_q != StIdle && state_q != StHalt) begin
                cycle_q <= cycle_q + CNT_W'(1);
            end
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    assign bus.imem_req    = imem_req;
    assign bus.PCWrite     = pc_write;
    assign bus.PCSrc       = pc_src;
    assign bus.IRWrite     = ir_write;
    assign bus.RegDst      = reg_dst;
    assign bus.MemReadEn   = mem_read_en;
    assign bus.MemtoReg    = mem_to_reg;
    assign bus.MemWriteEn  = mem_write_en;
    assign bus.RegWriteEn  = reg_write_en;
    assign bus.ALUSrc      = alu_src;
    assign bus.ALUOp       = ALUOP_W'(alu_op);
    assign bus.hlt         = hlt;
    assign bus.mem_err     = err_q;
    assign bus.cycle_cnt   = cycle_q;
    assign bus.retired_cnt = retired_q;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-state control vectors, stall
// handling, timeout, halt and asynchronous reset behaviour.
module tb_multicycle_control_unit;

    logic clk;
    logic rst;

    multicycle_control_unit_if bus ();

    multicycle_control_unit dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    // Packed view of all single-bit/select controls plus hlt and mem_err
    logic [16:0] obs;
    logic [16:0] expv;
    assign obs = {bus.imem_req, bus.PCWrite, bus.PCSrc, bus.IRWrite, bus.RegDst,
                  bus.MemReadEn, bus.MemtoReg, bus.MemWriteEn, bus.RegWriteEn,
                  bus.ALUSrc, bus.ALUOp, bus.hlt, bus.mem_err};

    function automatic logic [16:0] ctl(input logic req, input logic pcw,
                                        input logic [1:0] pcs, input logic irw,
                                        input logic rdst, input logic mrd,
                                        input logic m2r, input logic mwr,
                                        input logic rwr, input logic asrc,
                                        input logic [3:0] aop, input logic h,
                                        input logic e);
        return {req, pcw, pcs, irw, rdst, mrd, m2r, mwr, rwr, asrc, aop, h, e};
    endfunction

    // Advance to 2 time units after the next rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Hold reset for two cycles and release it; returns inside the IDLE cycle
    task automatic reset_dut();
        rst = 1'b0;
        bus.opcode = '0; bus.funct = '0; bus.alu_zero = 1'b0;
        bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.imem_ready = 1'b1; bus.dmem_ready = 1'b1; bus.alu_zero = 1'b1;
        bus.opcode = 6'h23; bus.funct = 6'h20;
        tick(); tick();
        #1;
        n_run++;
        if (obs !== 17'h0) begin
            n_fail++; $display("FAIL reset_ctl: got %h exp %h", obs, 17'h0);
        end
        n_run++;
        if (bus.cycle_cnt !== 32'd0 || bus.retired_cnt !== 32'd0) begin
            n_fail++; $display("FAIL reset_cnt: got %0d/%0d exp 0/0",
                               bus.cycle_cnt, bus.retired_cnt);
        end
        reset_dut();
        #1;
        n_run++;
        if (obs !== 17'h0) begin
            n_fail++; $display("FAIL idle_ctl: got %h exp %h", obs, 17'h0);
        end
        tick();
        #1;
        expv = ctl(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_run++;
        if (obs !== expv || bus.cycle_cnt !== 32'd0) begin
            n_fail++; $display("FAIL first_fetch: got %h/%0d exp %h/0", obs, bus.cycle_cnt, expv);
        end
    endtask

    task automatic test_add();
        reset_dut();
        tick();
        bus.imem_ready = 1'b1; bus.dmem_ready = 1'b1;
        bus.opcode = 6'h00; bus.funct = 6'h20;
        #1;
        expv = ctl(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_run++;
        if (obs !== expv) begin
            n_fail++; $display("FAIL add_fetch: got %h exp %h", obs, expv);
        end
        tick();
        bus.opcode = 6'h3F; bus.funct = 6'h3F;  // must not disturb latched instruction
        #1;
        n_run++;
        if (obs !== 17'h0) begin
            n_fail++; $display("FAIL add_decode: got %h exp %h", obs, 17'h0);
        end
        tick(); #1;
        expv = ctl(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 4'd0, 0, 0);
        n_run++;
        if (obs !== expv) begin
            n_fail++; $display("FAIL add_exec: got %h exp %h", obs, expv);
        end
        tick(); #1;
        expv = ctl(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 4'd0, 0, 0);
        n_run++;
        if (obs !== expv || bus.retired_cnt !== 32'd0) begin
            n_fail++; $display("FAIL add_wb: got %h/%0d exp %h/0", obs, bus.retired_cnt, expv);
        end
        tick();
        bus.imem_ready = 1'b0; bus.opcode = '0; bus.funct = '0;
        #1;
        expv = ctl(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_run++;
        if (obs !== expv || bus.retired_cnt !== 32'd1 || bus.cycle_cnt !== 32'd4) begin
            n_fail++; $display("FAIL add_retire: got %h ret=%0d cyc=%0d exp %h ret=1 cyc=4",
                               obs, bus.retired_cnt, bus.cycle_cnt, expv);
        end
    endtask

    task automatic test_alu_ops();
        logic [5:0] ops [12] = '{6'h00, 6'h0D, 6'h00, 6'h0A, 6'h00, 6'h00,
                                 6'h00, 6'h0E, 6'h0C, 6'h03, 6'h00, 6'h00};
        logic [5:0] fns [12] = '{6'h22, 6'h00, 6'h00, 6'h00, 6'h27, 6'h2B,
                                 6'h02, 6'h00, 6'h00, 6'h00, 6'h24, 6'h25};
        logic [3:0] aops [12] = '{4'd1, 4'd3, 4'd8, 4'd6, 4'd5, 4'd7,
                                  4'd9, 4'd4, 4'd2, 4'd0, 4'd2, 4'd3};
        logic srcs [12] = '{0, 1, 1, 1, 0, 0, 1, 1, 1, 1, 0, 0};
        logic rds  [12] = '{1, 0, 1, 0, 1, 1, 1, 0, 0, 1, 1, 1};
        reset_dut();
        tick();
        bus.imem_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.opcode = ops[i]; bus.funct = fns[i];
            #1;
            tick(); tick(); #1;
            expv = ctl(0, 0, 0, 0, rds[i], 0, 0, 0, 0, srcs[i], aops[i], 0, 0);
            n_run++;
            if (obs !== expv) begin
                n_fail++; $display("FAIL alu_exec[%0d]: got %h exp %h", i, obs, expv);
            end
            tick(); #1;
            expv = ctl(0, 0, 0, 0, rds[i], 0, 0, 0, 1, 0, 0, 0, 0);
            n_run++;
            if (obs !== expv) begin
                n_fail++; $display("FAIL alu_wb[%0d]: got %h exp %h", i, obs, expv);
            end
            tick();
        end
        bus.imem_ready = 1'b0;
        #1;
        n_run++;
        if (bus.retired_cnt !== 32'd12 || bus.cycle_cnt !== 32'd48) begin
            n_fail++; $display("FAIL alu_counts: got ret=%0d cyc=%0d exp ret=12 cyc=48",
                               bus.retired_cnt, bus.cycle_cnt);
        end
    endtask

    task automatic test_lw_wait();
        reset_dut();
        tick();
        bus.imem_ready = 1'b1; bus.opcode = 6'h23; bus.funct = 6'h00;
        tick();
        bus.imem_ready = 1'b0;
        tick(); #1;
        expv = ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        n_run++;
        if (obs !== expv) begin
            n_fail++; $display("FAIL lw_exec: got %h exp %h", obs, expv);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.dmem_ready = (i == 3);
            #1;
            expv = ctl(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
            n_run++;
            if (obs !== expv) begin
                n_fail++; $display("FAIL lw_mem[%0d]: got %h exp %h", i, obs, expv);
            end
        end
        tick();
        bus.dmem_ready = 1'b0;
        #1;
        expv = ctl(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        n_run++;
        if (obs !== expv) begin
            n_fail++; $display("FAIL lw_wb: got %h exp %h", obs, expv);
        end
        tick(); #1;
        expv = ctl(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_run++;
        if (obs !== expv || bus.retired_cnt !== 32'd1 || bus.cycle_cnt !== 32'd8) begin
            n_fail++; $display("FAIL lw_retire: got %h ret=%0d cyc=%0d exp %h ret=1 cyc=8",
                               obs, bus.retired_cnt, bus.cycle_cnt, expv);
        end
    endtask

    task automatic test_sw();
        reset_dut();
        tick();
        bus.imem_ready = 1'b1; bus.dmem_ready = 1'b1; bus.opcode = 6'h2B;
        tick(); tick(); tick(); #1;
        expv = ctl(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        n_run++;
        if (obs !== expv) begin
            n_fail++; $display("FAIL sw_mem: got %h exp %h", obs, expv);
        end
        tick();
        bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
        #1;
        n_run++;
        if (bus.retired_cnt !== 32'd1 || bus.cycle_cnt !== 32'd4 || bus.imem_req !== 1'b1) begin
            n_fail++; $display("FAIL sw_retire: got ret=%0d cyc=%0d req=%b exp ret=1 cyc=4 req=1",
                               bus.retired_cnt, bus.cycle_cnt, bus.imem_req);
        end
    endtask

    task automatic test_branch();
        logic [5:0] ops [4] = '{6'h04, 6'h04, 6'h05, 6'h05};
        logic zs  [4] = '{1, 0, 0, 1};
        logic tks [4] = '{1, 0, 1, 0};
        reset_dut();
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.imem_ready = 1'b1; bus.opcode = ops[i];
            tick();
            bus.imem_ready = 1'b0;
            tick();
            bus.alu_zero = zs[i];
            #1;
            expv = ctl(0, tks[i], tks[i] ? 2'd1 : 2'd0, 0, 0, 0, 0, 0, 0, 0, 4'd1, 0, 0);
            n_run++;
            if (obs !== expv) begin
                n_fail++; $display("FAIL branch[%0d]: got %h exp %h", i, obs, expv);
            end
            tick();
        end
        #1;
        n_run++;
        if (bus.retired_cnt !== 32'd4 || bus.cycle_cnt !== 32'd12) begin
            n_fail++; $display("FAIL branch_counts: got ret=%0d cyc=%0d exp ret=4 cyc=12",
                               bus.retired_cnt, bus.cycle_cnt);
        end
    endtask

    task automatic test_jump_and_nop();
        reset_dut();
        tick();
        bus.imem_ready = 1'b1; bus.opcode = 6'h02; bus.funct = 6'h00;
        tick(); #1;
        expv = ctl(0, 1, 2'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_run++;
        if (obs !== expv) begin
            n_fail++; $display("FAIL j_decode: got %h exp %h", obs, expv);
        end
        tick();
        bus.opcode = 6'h00; bus.funct = 6'h08;
        tick(); #1;
        expv = ctl(0, 1, 2'd3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_run++;
        if (obs !== expv) begin
            n_fail++; $display("FAIL jr_decode: got %h exp %h", obs, expv);
        end
        tick();
        bus.opcode = 6'h3E; bus.funct = 6'h00;
        tick(); #1;
        n_run++;
        if (obs !== 17'h0) begin
            n_fail++; $display("FAIL nop_op_decode: got %h exp %h", obs, 17'h0);
        end
        tick();
        bus.opcode = 6'h00; bus.funct = 6'h3F;
        #1;
        expv = ctl(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_run++;
        if (obs !== expv) begin
            n_fail++; $display("FAIL nop_refetch: got %h exp %h", obs, expv);
        end
        tick(); tick();
        bus.imem_ready = 1'b0;
        #1;
        n_run++;
        if (bus.retired_cnt !== 32'd2 || bus.cycle_cnt !== 32'd8 || bus.imem_req !== 1'b1) begin
            n_fail++; $display("FAIL jump_counts: got ret=%0d cyc=%0d req=%b exp ret=2 cyc=8 req=1",
                               bus.retired_cnt, bus.cycle_cnt, bus.imem_req);
        end
    endtask

    task automatic test_timeout();
        reset_dut();
        tick();
        for (int i = 0; i < 15; i++) begin
            #1;
            n_run++;
            if (bus.imem_req !== 1'b1 || bus.mem_err !== 1'b0) begin
                n_fail++; $display("FAIL tmo_wait[%0d]: got req=%b err=%b exp req=1 err=0",
                                   i, bus.imem_req, bus.mem_err);
            end
            tick();
        end
        #1;
        expv = ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        n_run++;
        if (obs !== expv || bus.cycle_cnt !== 32'd15) begin
            n_fail++; $display("FAIL tmo_halt: got %h/%0d exp %h/15", obs, bus.cycle_cnt, expv);
        end
        tick(); tick(); #1;
        n_run++;
        if (obs !== expv || bus.cycle_cnt !== 32'd15) begin
            n_fail++; $display("FAIL tmo_frozen: got %h/%0d exp %h/15", obs, bus.cycle_cnt, expv);
        end
    endtask

    task automatic test_late_ready();
        reset_dut();
        tick();
        repeat (14) tick();
        bus.imem_ready = 1'b1; bus.opcode = 6'h00; bus.funct = 6'h20;
        #1;
        expv = ctl(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_run++;
        if (obs !== expv) begin
            n_fail++; $display("FAIL late_ready_fetch: got %h exp %h", obs, expv);
        end
        tick();
        bus.imem_ready = 1'b0;
        #1;
        n_run++;
        if (obs !== 17'h0) begin
            n_fail++; $display("FAIL late_ready_decode: got %h exp %h", obs, 17'h0);
        end
    endtask

    task automatic test_halt();
        reset_dut();
        tick();
        bus.imem_ready = 1'b1; bus.opcode = 6'h3F;
        tick();
        bus.imem_ready = 1'b0;
        #1;
        n_run++;
        if (obs !== 17'h0) begin
            n_fail++; $display("FAIL hlt_decode: got %h exp %h", obs, 17'h0);
        end
        tick(); #1;
        expv = ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        n_run++;
        if (obs !== expv || bus.cycle_cnt !== 32'd2) begin
            n_fail++; $display("FAIL hlt_state: got %h/%0d exp %h/2", obs, bus.cycle_cnt, expv);
        end
        tick(); tick(); #1;
        n_run++;
        if (obs !== expv || bus.cycle_cnt !== 32'd2) begin
            n_fail++; $display("FAIL hlt_sticky: got %h/%0d exp %h/2", obs, bus.cycle_cnt, expv);
        end
        rst = 1'b0;
        #1;
        n_run++;
        if (obs !== 17'h0 || bus.cycle_cnt !== 32'd0) begin
            n_fail++; $display("FAIL hlt_reset: got %h/%0d exp 0/0", obs, bus.cycle_cnt);
        end
    endtask

    task automatic test_reset_mid_sw();
        reset_dut();
        tick();
        bus.imem_ready = 1'b1; bus.opcode = 6'h2B;
        tick();
        bus.imem_ready = 1'b0;
        tick(); tick(); #1;
        expv = ctl(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        n_run++;
        if (obs !== expv) begin
            n_fail++; $display("FAIL sw_wait: got %h exp %h", obs, expv);
        end
        #1;
        rst = 1'b0;
        #1;
        n_run++;
        if (obs !== 17'h0) begin
            n_fail++; $display("FAIL sw_async_reset: got %h exp %h", obs, 17'h0);
        end
        tick(); tick();
        rst = 1'b1;
        #1;
        n_run++;
        if (obs !== 17'h0) begin
            n_fail++; $display("FAIL post_reset_idle: got %h exp %h", obs, 17'h0);
        end
        tick(); #1;
        expv = ctl(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_run++;
        if (obs !== expv || bus.cycle_cnt !== 32'd0 || bus.retired_cnt !== 32'd0) begin
            n_fail++; $display("FAIL post_reset_fetch: got %h cyc=%0d ret=%0d exp %h 0 0",
                               obs, bus.cycle_cnt, bus.retired_cnt, expv);
        end
    endtask

    initial begin
        rst = 1'b0;
        test_reset();
        test_add();
        test_alu_ops();
        test_lw_wait();
        test_sw();
        test_branch();
        test_jump_and_nop();
        test_timeout();
        test_late_ready();
        test_halt();
        test_reset_mid_sw();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
